// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute unit: one-cycle logic/arith ops and an iterative 1-bit-per-cycle shifter.
// Define ALU_EXEC_BYPASS_EN to accept a new request on the edge that drains the held result.
module alu_exec_unit #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    localparam logic [1:0] SH_LL = 2'b00;
    localparam logic [1:0] SH_RL = 2'b01;
    localparam logic [1:0] SH_RA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_d, start_state;
    logic [XLEN-1:0]   acc, acc_nxt;
    logic [SHW-1:0]    cnt;
    logic [1:0]        sop;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ill;
    logic              is_shift;
    logic              accept;
    logic [SHW-1:0]    shamt;

    assign shamt = op_b[SHW-1:0];

    // Single-cycle datapath, evaluated against the live request inputs
    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        is_shift = 1'b0;
        case (alu_ctrl)
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_ADD: alu_res = op_a + op_b;
            OP_SUB: alu_res = op_a - op_b;
            OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLL, OP_SRL, OP_SRA: is_shift = 1'b1;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        acc_nxt = acc;
        case (sop)
            SH_LL:   acc_nxt = {acc[XLEN-2:0], 1'b0};
            SH_RL:   acc_nxt = {1'b0, acc[XLEN-1:1]};
            SH_RA:   acc_nxt = {acc[XLEN-1], acc[XLEN-1:1]};
            default: acc_nxt = acc;
        endcase
    end

    assign out_valid = (state == HOLD);
`ifdef ALU_EXEC_BYPASS_EN
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
`else
    assign in_ready  = (state == IDLE);
`endif
    assign accept      = in_valid && in_ready;
    assign start_state = (is_shift && (shamt != '0)) ? SHIFT : HOLD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (in_valid) state_d = start_state;
            SHIFT: if (cnt == SHW'(1)) state_d = HOLD;
            HOLD: begin
                if (out_ready) begin
`ifdef ALU_EXEC_BYPASS_EN
                    state_d = in_valid ? start_state : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            sop     <= SH_LL;
        end else if (accept) begin
            if (is_shift) begin
                acc <= op_a;
                cnt <= shamt;
                sop <= alu_ctrl[1:0];
                // A zero shift amount bypasses the iterative shifter entirely
                if (shamt == '0) begin
                    result  <= op_a;
                    zero    <= (op_a == '0);
                    illegal <= 1'b0;
                end
            end else begin
                result  <= alu_res;
                zero    <= (alu_res == '0);
                illegal <= alu_ill;
            end
        end else if (state == SHIFT) begin
            acc <= acc_nxt;
            cnt <= cnt - SHW'(1);
            if (cnt == SHW'(1)) begin
                result  <= acc_nxt;
                zero    <= (acc_nxt == '0);
                illegal <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops against a behavioural model.
module tb_alu_exec_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a, op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: what the op means, and how many edges it takes
    function automatic void ref_op(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   output logic [XLEN-1:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b % XLEN);
        ill = 1'b0;
        lat = 1;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd6:  r = a - b;
            4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'd8:  begin r = a << sh; lat = 1 + sh; end
            4'd9:  begin r = a >> sh; lat = 1 + sh; end
            4'd10: begin r = XLEN'($signed(a) >>> sh); lat = 1 + sh; end
            default: begin r = '0; ill = 1'b1; end
        endcase
    endfunction

    task automatic run_op(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int hold, input string tag);
        logic [XLEN-1:0] er;
        logic            eill;
        int              elat;
        int              n;
        ref_op(c, a, b, er, eill, elat);
        n = 0;
        while (!in_ready && n < 40) begin tick; n++; end
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        alu_ctrl  = c; op_a = a; op_b = b; in_valid = 1'b1;
        out_ready = (hold == 0);
        tick;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
        n = 1;
        while (!out_valid && n < XLEN + 4) begin
            chk({tag, ".in_ready_busy"}, in_ready, 0);
            tick;
            n++;
        end
        chk({tag, ".latency"}, n, elat);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".result"}, result, er);
        chk({tag, ".zero"}, zero, (er == '0));
        chk({tag, ".illegal"}, illegal, eill);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_result"}, result, er);
            chk({tag, ".hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        chk({tag, ".drained"}, out_valid, 0);
        n_vec++;
    endtask

    initial begin
        logic [3:0] codes [8] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        int         seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = '0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.result", result, 0);
        chk("rst.zero", zero, 0);
        chk("rst.illegal", illegal, 0);
        rst_n = 1'b1;
        tick;

        run_op(4'b0010, 32'd5, 32'd7, 0, "add");
        run_op(4'b0110, 32'd3, 32'd3, 0, "sub_eq");
        run_op(4'b0110, 32'd0, 32'd1, 0, "sub_wrap");
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0, "slt_neg");
        run_op(4'b1010, 32'h8000_0000, 32'd4, 0, "sra4");
        run_op(4'b1000, 32'd1, 32'd0, 0, "sll0");
        run_op(4'b1001, 32'h8000_0000, 32'd31, 1, "srl31");
        run_op(4'b0010, 32'd1, 32'd1, 3, "add_bp");
        run_op(4'b1111, 32'd9, 32'd9, 0, "illegal");

`ifdef ALU_EXEC_BYPASS_EN
        // Held ADD drained on the same edge a queued OR is accepted
        alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        chk("byp.held_result", result, 32'd2);
        chk("byp.held_in_ready", in_ready, 0);
        alu_ctrl = 4'b0001; op_a = 32'hF0; op_b = 32'h0F; in_valid = 1'b1; out_ready = 1'b1;
        chk("byp.in_ready_comb", in_ready, 1);
        tick;
        in_valid = 1'b0;
        chk("byp.out_valid", out_valid, 1);
        chk("byp.result", result, 32'hFF);
        tick;
        chk("byp.drained", out_valid, 0);
        n_vec++;
`endif

        // Reset in the middle of a long shift
        out_ready = 1'b1;
        alu_ctrl = 4'b1000; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.result", result, 0);
        chk("midrst.in_ready", in_ready, 1);
        tick;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (out_valid) seen++;
        end
        chk("midrst.no_ghost", seen, 0);
        run_op(4'b0010, 32'd2, 32'd2, 0, "post_rst_add");

        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 7)];
            run_op(c, $urandom, $urandom, $urandom_range(0, 2), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
